ws2812b_bit_encoder: RTL and testbench

WS2812B_BIT_ENCODER -- requirements
Module: ws2812b_bit_encoder

---
 rtl/ws2812b_pkg.sv | 17 +
 rtl/ws2812b_bit_encoder_if.sv | 24 ++
 rtl/ws2812b_bit_timer.sv | 41 ++++
 rtl/ws2812b_bit_encoder.sv | 194 +++++++++++++++++++
 tb/tb_ws2812b_bit_encoder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812b_pkg.sv
// Shared types and default WS2812B timing (64 MHz core clock) for the bit encoder.
// Pure definitions: no logic, no latency.
package ws2812b_pkg;

    localparam int DEF_T0H_CYCLES   = 26;
    localparam int DEF_T1H_CYCLES   = 51;
    localparam int DEF_BIT_CYCLES   = 80;
    localparam int DEF_LATCH_CYCLES = 19200;
    localparam int PIXEL_BITS       = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/ws2812b_bit_encoder_if.sv
// Pixel handshake into the encoder: GRB word plus latch request, valid/ready.
// Master offers the pixel, slave (the encoder) accepts on valid && ready.
interface ws2812b_bit_encoder_if;

    logic [23:0] data_in;
    logic        valid;
    logic        latch;
    logic        ready;

    modport master (
        output data_in,
        output valid,
        output latch,
        input  ready
    );

    modport slave (
        input  data_in,
        input  valid,
        input  latch,
        output ready
    );

endinterface

// File: rtl/ws2812b_bit_timer.sv
// Cycle counter with terminal-count done pulse and next-cycle high/low compare.
// Zero latency: done and high_nxt are combinational from the registered count.
module ws2812b_bit_timer #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    input  logic [CNT_W-1:0] i_high_len,
    output logic             o_done,
    output logic             o_high_nxt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign o_done = i_en && (r_cnt == i_term);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_en) begin
            w_cnt_nxt = o_done ? '0 : r_cnt + 1'b1;
        end
    end

    // The output pin is registered upstream, so the compare looks one cycle ahead.
    assign o_high_nxt = (w_cnt_nxt < i_high_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/ws2812b_bit_encoder.sv
// WS2812B serialiser: 24-bit GRB pixel, MSB first, led rises the cycle after acceptance.
// ready only in IDLE; WS2812B_BIT_ENCODER_BUFFER_EN adds a one-pixel holding buffer for gapless streams.
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
#(
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ws2812b_bit_encoder_if.slave  pix,
    output logic                  led
);

    localparam int CNT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [CNT_W-1:0] T0H_LEN    = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_LEN    = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] BIT_TERM   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_TERM = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]       TOP_BIT    = 5'(PIXEL_BITS - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && BIT_CYCLES <= LATCH_CYCLES)) begin : g_param_check
        $fatal(1, "ws2812b_bit_encoder: illegal timing parameters");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_bit_idx;
    logic [4:0]  w_bit_idx_nxt;
    logic [23:0] r_data;
    logic [23:0] w_data_nxt;
    logic        r_latch;
    logic        w_latch_nxt;
    logic        r_led;
    logic        w_led_nxt;
    logic        w_start;

    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic [CNT_W-1:0] w_tmr_term;
    logic [CNT_W-1:0] w_tmr_high;
    logic             w_tmr_done;
    logic             w_tmr_high_nxt;

    // Next pixel source: either straight from the port or from the holding buffer.
    logic        w_src_vld;
    logic [23:0] w_src_data;
    logic        w_src_latch;

`ifdef WS2812B_BIT_ENCODER_BUFFER_EN
    logic        r_run;
    logic        r_buf_vld;
    logic [23:0] r_buf_data;
    logic        r_buf_latch;
    logic        w_acc;

    // r_run keeps ready low while in reset and for the first cycle after release.
    assign pix.ready   = r_run && !r_buf_vld;
    assign w_acc       = pix.valid && pix.ready;
    assign w_src_vld   = r_buf_vld || w_acc;
    assign w_src_data  = r_buf_vld ? r_buf_data  : pix.data_in;
    assign w_src_latch = r_buf_vld ? r_buf_latch : pix.latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_buf_vld   <= 1'b0;
            r_buf_data  <= '0;
            r_buf_latch <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_start) begin
                r_buf_vld <= 1'b0;
            end else if (w_acc) begin
                r_buf_vld   <= 1'b1;
                r_buf_data  <= pix.data_in;
                r_buf_latch <= pix.latch;
            end
        end
    end
`else
    assign pix.ready   = (r_state == IDLE);
    assign w_src_vld   = pix.valid && pix.ready;
    assign w_src_data  = pix.data_in;
    assign w_src_latch = pix.latch;
`endif

    ws2812b_bit_timer #(
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_tmr_clr),
        .i_en       (w_tmr_en),
        .i_term     (w_tmr_term),
        .i_high_len (w_tmr_high),
        .o_done     (w_tmr_done),
        .o_high_nxt (w_tmr_high_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LATCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_data_nxt    = r_data;
        w_latch_nxt   = r_latch;
        w_led_nxt     = 1'b0;
        w_start       = 1'b0;
        w_tmr_clr     = 1'b0;
        w_tmr_en      = 1'b0;
        w_tmr_term    = BIT_TERM;
        w_tmr_high    = T0H_LEN;

        case (r_state)
            IDLE: begin
                if (w_src_vld) begin
                    w_start = 1'b1;
                end
            end
            SEND: begin
                w_tmr_en   = 1'b1;
                w_tmr_high = r_data[r_bit_idx] ? T1H_LEN : T0H_LEN;
                w_led_nxt  = w_tmr_high_nxt;
                if (w_tmr_done) begin
                    if (r_bit_idx == 5'd0) begin
                        w_led_nxt = 1'b0;
                        if (r_latch) begin
                            w_state_nxt = LATCH;
                        end else if (w_src_vld) begin
                            w_start = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx - 1'b1;
                    end
                end
            end
            LATCH: begin
                w_tmr_en   = 1'b1;
                w_tmr_term = LATCH_TERM;
                w_tmr_high = '0;
                if (w_tmr_done) begin
                    if (w_src_vld) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = LATCH;
            end
        endcase

        // Loading a pixel overrides whatever the state above decided.
        if (w_start) begin
            w_state_nxt   = SEND;
            w_data_nxt    = w_src_data;
            w_latch_nxt   = w_src_latch;
            w_bit_idx_nxt = TOP_BIT;
            w_tmr_clr     = 1'b1;
            w_led_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= '0;
            r_data    <= '0;
            r_latch   <= 1'b0;
            r_led     <= 1'b0;
        end else begin
            r_bit_idx <= w_bit_idx_nxt;
            r_data    <= w_data_nxt;
            r_latch   <= w_latch_nxt;
            r_led     <= w_led_nxt;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_ws2812b_bit_encoder.sv
// Bench for ws2812b_bit_encoder: per-cycle waveform model plus literal timing pins.
module tb_ws2812b_bit_encoder;

    localparam int T0H  = 26;
    localparam int T1H  = 51;
    localparam int BITC = 80;
    localparam int LATC = 19200;

    logic clk = 1'b0;
    logic rst_n;
    logic led;

    ws2812b_bit_encoder_if pix ();

    ws2812b_bit_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pix),
        .led   (led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected led level for each upcoming cycle; empty queue means idle.
    bit          wave_q[$];
    bit          pend_vld;
    logic [23:0] pend_d;
    bit          pend_l;
    bit          first_cyc;
    bit          exp_led;
    bit          exp_rdy;

    int hw_q[$];
    int run_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_pixel(input logic [23:0] d, input bit l);
        for (int b = 23; b >= 0; b--) begin
            for (int c = 0; c < BITC; c++) begin
                wave_q.push_back(c < (d[b] ? T1H : T0H));
            end
        end
        if (l) begin
            for (int c = 0; c < LATC; c++) wave_q.push_back(1'b0);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_led_m", {31'd0, led}, 32'd0);
            chk("rst_rdy_m", {31'd0, pix.ready}, 32'd0);
            wave_q.delete();
            for (int c = 0; c < LATC; c++) wave_q.push_back(1'b0);
            pend_vld  = 1'b0;
            first_cyc = 1'b1;
        end else begin
            exp_led = (wave_q.size() != 0) ? wave_q[0] : 1'b0;
`ifdef WS2812B_BIT_ENCODER_BUFFER_EN
            exp_rdy = !pend_vld && !first_cyc;
`else
            exp_rdy = (wave_q.size() == 0);
`endif
            chk("led_model", {31'd0, led}, {31'd0, exp_led});
            chk("ready_model", {31'd0, pix.ready}, {31'd0, exp_rdy});
            first_cyc = 1'b0;
            if (wave_q.size() != 0) void'(wave_q.pop_front());
`ifdef WS2812B_BIT_ENCODER_BUFFER_EN
            if (wave_q.size() == 0 && pend_vld) begin
                push_pixel(pend_d, pend_l);
                pend_vld = 1'b0;
            end
            if (pix.valid && exp_rdy) begin
                if (wave_q.size() == 0) begin
                    push_pixel(pix.data_in, pix.latch);
                end else begin
                    pend_vld = 1'b1;
                    pend_d   = pix.data_in;
                    pend_l   = pix.latch;
                end
            end
`else
            if (pix.valid && exp_rdy) push_pixel(pix.data_in, pix.latch);
`endif
        end
    end

    // High-pulse width recorder.
    always @(negedge clk) begin
        if (led === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            hw_q.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (pix.ready !== 1'b1 && n < 40000) begin
            tick();
            n++;
        end
        chk(name, {31'd0, pix.ready}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((wave_q.size() != 0 || pend_vld) && n < 45000) begin
            tick();
            n++;
        end
        if (n >= 45000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout got %0d queued expected 0", name, wave_q.size());
        end
    endtask

    task automatic cycles_to_ready(output int n);
        n = 0;
        while (pix.ready !== 1'b1 && n < 40000) begin
            n++;
            tick();
        end
    endtask

    task automatic send(input logic [23:0] d, input bit l);
        wait_ready("send_ready");
        pix.data_in = d;
        pix.latch   = l;
        pix.valid   = 1'b1;
        tick();
        pix.valid   = 1'b0;
        pix.latch   = 1'b0;
        pix.data_in = 24'($urandom);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n26;
        rst_n       = 1'b0;
        pix.valid   = 1'b0;
        pix.latch   = 1'b0;
        pix.data_in = '0;
        repeat (3) tick();
        chk("rst_led", {31'd0, led}, 32'd0);
        chk("rst_ready", {31'd0, pix.ready}, 32'd0);

        // Post-reset latch with a stray valid at cycle 100.
        rst_n = 1'b1;
        hw_q.delete();
        cnt = 0;
        while (pix.ready !== 1'b1 && cnt < 30000) begin
            cnt++;
            pix.valid   = (cnt == 100);
            pix.data_in = 24'hFFFFFF;
            tick();
        end
        pix.valid = 1'b0;
`ifndef WS2812B_BIT_ENCODER_BUFFER_EN
        chk("post_rst_ready_low", cnt, 32'd19200);
        chk("post_rst_no_pulse", hw_q.size(), 32'd0);
`endif
        wait_done("post_rst_done");

        // 800001, no latch.
        hw_q.delete();
        send(24'h800001, 1'b0);
`ifndef WS2812B_BIT_ENCODER_BUFFER_EN
        cycles_to_ready(cnt);
        chk("px800001_ready_after", cnt, 32'd1920);
`endif
        wait_done("px800001_done");
        n26 = 0;
        for (int i = 1; i < 23; i++) if (hw_q[i] == T0H) n26++;
        chk("px800001_pulses", hw_q.size(), 32'd24);
        chk("px800001_first_w", hw_q[0], 32'd51);
        chk("px800001_mid_w26", n26, 32'd22);
        chk("px800001_last_w", hw_q[23], 32'd51);

        // 000000 with latch.
        hw_q.delete();
        send(24'h000000, 1'b1);
`ifndef WS2812B_BIT_ENCODER_BUFFER_EN
        cycles_to_ready(cnt);
        chk("px000000_latch_ready_after", cnt, 32'd21120);
`endif
        wait_done("px000000_done");
        chk("px000000_pulses", hw_q.size(), 32'd24);
        chk("px000000_first_w", hw_q[0], 32'd26);
        chk("px000000_last_w", hw_q[23], 32'd26);

        // Reset at cycle 500 of an all-ones pixel.
        send(24'hFFFFFF, 1'b0);
        repeat (499) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led_now", {31'd0, led}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        hw_q.delete();
`ifndef WS2812B_BIT_ENCODER_BUFFER_EN
        cycles_to_ready(cnt);
        chk("mid_rst_latch_len", cnt, 32'd19200);
`endif
        wait_done("mid_rst_done");
        chk("mid_rst_no_residual", hw_q.size(), 32'd0);

        // valid held high while data_in churns during SEND.
        wait_ready("hold_ready");
        hw_q.delete();
        pix.data_in = 24'h5A0F3C;
        pix.latch   = 1'b0;
        pix.valid   = 1'b1;
        repeat (1000) begin
            tick();
            pix.data_in = 24'($urandom);
        end
        pix.valid = 1'b0;
        wait_done("hold_done");
        chk("hold_bit23_w", hw_q[0], 32'd26);
        chk("hold_bit22_w", hw_q[1], 32'd51);

`ifdef WS2812B_BIT_ENCODER_BUFFER_EN
        hw_q.delete();
        send(24'hAAAAAA, 1'b0);
        send(24'h555555, 1'b0);
        wait_done("b2b_done");
        chk("b2b_pulses", hw_q.size(), 32'd48);
        chk("b2b_first_w", hw_q[0], 32'd51);
        chk("b2b_px0_bit0_w", hw_q[23], 32'd26);
        chk("b2b_px1_bit23_w", hw_q[24], 32'd26);
        chk("b2b_last_w", hw_q[47], 32'd51);
`endif

        // Random pixels with short random gaps.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(24'($urandom), 1'b0);
        end
        wait_done("random_done");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
